stage_act: RTL and testbench

- ReLU activation stage placed directly downstream of stage.
- Forward path: takes the float_24_8 st_data_out stream, applies ReLU, and forwards the result to the next layer.
- Per-element sign mask: recorded during the forward pass and held for one frame.
- Backward path: gates the error stream from the next layer with the mask (error × relu′(x)). The result drives stage's st_error input.

---
 rtl/stage_act_pkg.sv | 19 +
 rtl/stage_act_mask.sv | 26 ++
 rtl/stage_act.sv | 158 +++++++++++++++
 tb/tb_stage_act.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_act_pkg.sv
// Shared types for the ReLU activation stage: float_24_8 word, zero constant,
// sign test and the forward/backward state encoding.
package stage_act_pkg;

    // Packed {mantissa[23:0] two's complement, exponent[7:0]}
    typedef logic [31:0] float_24_8;

    localparam float_24_8 FLT_ZERO = 32'h0;

    typedef enum logic {
        StFwd,
        StBwd
    } act_state_e;

    function automatic logic flt_is_neg(input float_24_8 v);
        return v[31];
    endfunction

endpackage

// File: rtl/stage_act_mask.sv
// Per-element ReLU derivative mask: MAX_LEN x 1 register file,
// one synchronous write port and one combinational read port.
module stage_act_mask #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned AW      = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_bit,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_bit
);

    logic [MAX_LEN-1:0] mem;

    // No reset: contents are only read back after the forward pass wrote them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_bit;
        end
    end

    assign rd_bit = mem[rd_addr];

endmodule

// File: rtl/stage_act.sv
// ReLU activation stage: forward path applies ReLU and records the sign mask,
// backward path gates the downstream error with that mask.
module stage_act
    import stage_act_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned LEN_W   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LEN_W-1:0] act_length,
    input  logic             act_bypass,
    input  logic [31:0]      act_in,
    input  logic             act_in_fst,
    input  logic             act_in_vld,
    output logic             act_in_rdy,
    output logic [31:0]      act_out,
    output logic             act_out_fst,
    output logic             act_out_vld,
    input  logic             act_out_rdy,
    input  logic [31:0]      err_in,
    input  logic             err_in_fst,
    input  logic             err_in_vld,
    output logic             err_in_rdy,
    output logic [31:0]      err_out,
    output logic             err_out_fst,
    output logic             err_out_vld,
    input  logic             err_out_rdy
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    act_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_clip, len_used, wr_idx, rd_idx;
    logic             act_load, err_load;
    logic             fwd_acc, bwd_acc;
    logic             mask_wr_bit, mask_rd_bit;
    float_24_8        act_relu;

    always_comb begin
        len_clip = act_length;
        if (act_length == '0) begin
            len_clip = LEN_W'(1);
        end else if (act_length > LEN_W'(MAX_LEN)) begin
            len_clip = LEN_W'(MAX_LEN);
        end
    end

    // Each output register can take a new word when empty or being drained
    assign act_load = !act_out_vld || act_out_rdy;
    assign err_load = !err_out_vld || err_out_rdy;

    assign act_in_rdy = !reset && (state_q == StFwd) && act_load;
    assign err_in_rdy = !reset && (state_q == StBwd) && err_load;

    assign fwd_acc = act_in_vld && act_in_rdy;
    assign bwd_acc = err_in_vld && err_in_rdy;

    // fst re-synchronises either stream to element 0
    assign wr_idx   = act_in_fst ? '0 : wr_ptr_q;
    assign rd_idx   = err_in_fst ? '0 : rd_ptr_q;
    assign len_used = act_in_fst ? len_clip : len_q;

    assign mask_wr_bit = act_bypass || !flt_is_neg(act_in);
    assign act_relu    = mask_wr_bit ? act_in : FLT_ZERO;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        unique case (state_q)
            StFwd: begin
                if (fwd_acc) begin
                    if (act_in_fst) begin
                        len_d = len_clip;
                    end
                    if (wr_idx == len_used - LEN_W'(1)) begin
                        state_d  = StBwd;
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_idx + LEN_W'(1);
                    end
                end
            end
            StBwd: begin
                if (bwd_acc) begin
                    if (rd_idx == len_q - LEN_W'(1)) begin
                        state_d  = StFwd;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_idx + LEN_W'(1);
                    end
                end
            end
            default: state_d = StFwd;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StFwd;
            len_q    <= LEN_W'(1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    stage_act_mask #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_mask (
        .clk     (clk),
        .wr_en   (fwd_acc),
        .wr_addr (wr_idx[AW-1:0]),
        .wr_bit  (mask_wr_bit),
        .rd_addr (rd_idx[AW-1:0]),
        .rd_bit  (mask_rd_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_out_vld <= 1'b0;
            act_out_fst <= 1'b0;
            act_out     <= FLT_ZERO;
        end else if (act_load) begin
            act_out_vld <= fwd_acc;
            if (fwd_acc) begin
                act_out_fst <= act_in_fst;
                act_out     <= act_relu;
            end
        end
    end

    // Backward fst is regenerated from the element index, not carried from err_in_fst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_out_vld <= 1'b0;
            err_out_fst <= 1'b0;
            err_out     <= FLT_ZERO;
        end else if (err_load) begin
            err_out_vld <= bwd_acc;
            if (bwd_acc) begin
                err_out_fst <= (rd_idx == '0);
                err_out     <= mask_rd_bit ? err_in : FLT_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_stage_act.sv
// Bench for stage_act: directed scenarios plus randomized frames, all checked
// against a queue-based model of the ReLU / mask / gating rules.
module tb_stage_act;

    localparam int MAX_LEN = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  act_length = 7'd1;
    logic        act_bypass = 1'b0;
    logic [31:0] act_in = '0;
    logic        act_in_fst = 1'b0;
    logic        act_in_vld = 1'b0;
    logic        act_in_rdy;
    logic [31:0] act_out;
    logic        act_out_fst;
    logic        act_out_vld;
    logic        act_out_rdy = 1'b1;
    logic [31:0] err_in = '0;
    logic        err_in_fst = 1'b0;
    logic        err_in_vld = 1'b0;
    logic        err_in_rdy;
    logic [31:0] err_out;
    logic        err_out_fst;
    logic        err_out_vld;
    logic        err_out_rdy = 1'b1;

    always #5 clk = ~clk;

    stage_act #(
        .MAX_LEN (64),
        .LEN_W   (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .act_length  (act_length),
        .act_bypass  (act_bypass),
        .act_in      (act_in),
        .act_in_fst  (act_in_fst),
        .act_in_vld  (act_in_vld),
        .act_in_rdy  (act_in_rdy),
        .act_out     (act_out),
        .act_out_fst (act_out_fst),
        .act_out_vld (act_out_vld),
        .act_out_rdy (act_out_rdy),
        .err_in      (err_in),
        .err_in_fst  (err_in_fst),
        .err_in_vld  (err_in_vld),
        .err_in_rdy  (err_in_rdy),
        .err_out     (err_out),
        .err_out_fst (err_out_fst),
        .err_out_vld (err_out_vld),
        .err_out_rdy (err_out_rdy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase flag, element count, frame length, mask, pending outputs
    bit          m_fwd;
    int          m_cnt;
    int          m_len;
    bit          m_mask [MAX_LEN];
    logic [32:0] qa[$];
    logic [32:0] qe[$];
    logic [31:0] got_a[$];
    logic [31:0] got_e[$];
    logic        got_af[$];
    logic        got_ef[$];
    logic [31:0] vec[$];
    logic        fvec[$];

    task automatic model_reset();
        m_fwd = 1'b1;
        m_cnt = 0;
        m_len = 1;
        qa.delete();
        qe.delete();
    endtask

    task automatic clear_got();
        got_a.delete();
        got_af.delete();
        got_e.delete();
        got_ef.delete();
    endtask

    task automatic model_fwd(input logic f, input logic [31:0] d, input logic [6:0] len,
                             input logic byp);
        int  idx;
        bit  pos;
        idx = f ? 0 : m_cnt;
        if (f) begin
            m_len = int'(len);
            if (m_len == 0) m_len = 1;
            if (m_len > MAX_LEN) m_len = MAX_LEN;
        end
        pos = byp || !d[31];
        m_mask[idx] = pos;
        qa.push_back({f, pos ? d : 32'h0});
        m_cnt = idx + 1;
        if (m_cnt >= m_len) begin
            m_fwd = 1'b0;
            m_cnt = 0;
        end
    endtask

    task automatic model_bwd(input logic f, input logic [31:0] d);
        int idx;
        idx = f ? 0 : m_cnt;
        qe.push_back({idx == 0, m_mask[idx] ? d : 32'h0});
        m_cnt = idx + 1;
        if (m_cnt >= m_len) begin
            m_fwd = 1'b1;
            m_cnt = 0;
        end
    endtask

    task automatic drive_cycle(input logic av, input logic af, input logic [31:0] ad,
                               input logic [6:0] len, input logic byp,
                               input logic ev, input logic ef, input logic [31:0] ed,
                               input logic ar, input logic er,
                               output bit aacc, output bit eacc);
        bit          exp_air;
        bit          exp_eir;
        logic [32:0] head;
        @(negedge clk);
        act_in_vld = av; act_in_fst = af; act_in = ad; act_length = len; act_bypass = byp;
        err_in_vld = ev; err_in_fst = ef; err_in = ed;
        act_out_rdy = ar; err_out_rdy = er;
        #1;
        exp_air = m_fwd && (qa.size() == 0 || ar);
        exp_eir = !m_fwd && (qe.size() == 0 || er);
        checks += 4;
        if (act_in_rdy !== exp_air) begin
            errors++;
            $display("FAIL act_in_rdy: got %b want %b at %0t", act_in_rdy, exp_air, $time);
        end
        if (err_in_rdy !== exp_eir) begin
            errors++;
            $display("FAIL err_in_rdy: got %b want %b at %0t", err_in_rdy, exp_eir, $time);
        end
        if (act_out_vld !== (qa.size() != 0)) begin
            errors++;
            $display("FAIL act_out_vld: got %b want %b at %0t", act_out_vld, qa.size() != 0,
                     $time);
        end
        if (err_out_vld !== (qe.size() != 0)) begin
            errors++;
            $display("FAIL err_out_vld: got %b want %b at %0t", err_out_vld, qe.size() != 0,
                     $time);
        end
        if (qa.size() != 0) begin
            checks++;
            if ({act_out_fst, act_out} !== qa[0]) begin
                errors++;
                $display("FAIL act_out: got fst=%b %h want %h at %0t", act_out_fst, act_out,
                         qa[0], $time);
            end
            if (ar) begin
                head = qa.pop_front();
                got_af.push_back(head[32]);
                got_a.push_back(head[31:0]);
            end
        end
        if (qe.size() != 0) begin
            checks++;
            if ({err_out_fst, err_out} !== qe[0]) begin
                errors++;
                $display("FAIL err_out: got fst=%b %h want %h at %0t", err_out_fst, err_out,
                         qe[0], $time);
            end
            if (er) begin
                head = qe.pop_front();
                got_ef.push_back(head[32]);
                got_e.push_back(head[31:0]);
            end
        end
        aacc = av && exp_air;
        eacc = ev && exp_eir;
        if (aacc) model_fwd(af, ad, len, byp);
        if (eacc) model_bwd(ef, ed);
    endtask

    // mode: 0 rdy high, 1 rdy toggling 1010.., 2 random rdy, gaps and mid-frame length noise
    task automatic push_fwd(input logic [6:0] len, input logic byp, input int mode);
        int         i = 0;
        int         guard = 0;
        bit         aa, ea;
        logic       ar, av;
        logic [6:0] l;
        while (i < vec.size() && guard < 2000) begin
            ar = (mode == 1) ? ~guard[0] : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            av = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            l  = (mode == 2 && !fvec[i]) ? 7'($urandom_range(0, 127)) : len;
            drive_cycle(av, fvec[i], vec[i], l, byp, 1'b0, 1'b0, 32'h0, ar, 1'b1, aa, ea);
            if (aa) i++;
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL push_fwd timeout: accepted %0d want %0d", i, vec.size());
        end
    endtask

    task automatic push_bwd(input int mode, input bit hold_av);
        int   i = 0;
        int   guard = 0;
        bit   aa, ea;
        logic er, ev;
        while (i < vec.size() && guard < 2000) begin
            er = (mode == 1) ? ~guard[0] : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            ev = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_cycle(hold_av, 1'b0, 32'h1234_5601, 7'd4, 1'b0, ev, fvec[i], vec[i],
                        1'b1, er, aa, ea);
            if (ea) i++;
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL push_bwd timeout: accepted %0d want %0d", i, vec.size());
        end
    endtask

    task automatic drain();
        int guard = 0;
        bit aa, ea;
        do begin
            drive_cycle(1'b0, 1'b0, 32'h0, 7'd1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, aa, ea);
            guard++;
        end while ((qa.size() != 0 || qe.size() != 0) && guard < 50);
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL drain timeout: pending act %0d err %0d", qa.size(), qe.size());
        end
    endtask

    task automatic rand_frame(input int n);
        logic [31:0] d;
        vec.delete();
        fvec.delete();
        for (int k = 0; k < n; k++) begin
            d = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
            vec.push_back(d);
            fvec.push_back(k == 0);
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 3;
        if ({act_out_vld, err_out_vld, act_out_fst, err_out_fst} !== 4'b0) begin
            errors++;
            $display("FAIL reset_vld_fst: got %b want 0000",
                     {act_out_vld, err_out_vld, act_out_fst, err_out_fst});
        end
        if ({act_out, err_out} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h want 0", act_out, err_out);
        end
        if ({act_in_rdy, err_in_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rdy: got %b want 00", {act_in_rdy, err_in_rdy});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (act_in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL release_rdy: got %b want 1", act_in_rdy);
        end
    endtask

    task automatic test_fwd_relu();
        logic [31:0] exp_a [4];
        exp_a = '{32'h3F80_0001, 32'h0, 32'h0, 32'h7FFF_FF05};
        vec  = '{32'h3F80_0001, 32'h8000_0001, 32'h0000_0000, 32'h7FFF_FF05};
        fvec = '{1'b1, 1'b0, 1'b0, 1'b0};
        clear_got();
        push_fwd(7'd4, 1'b0, 0);
        drain();
        checks++;
        if (got_a.size() != 4) begin
            errors++;
            $display("FAIL relu_count: got %0d want 4", got_a.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_a[k] !== exp_a[k] || got_af[k] !== (k == 0)) begin
                    errors++;
                    $display("FAIL relu_elem%0d: got %h fst %b want %h fst %b", k, got_a[k],
                             got_af[k], exp_a[k], k == 0);
                end
            end
        end
        checks++;
        if ({act_in_rdy, err_in_rdy} !== 2'b01) begin
            errors++;
            $display("FAIL relu_to_bwd: got rdy %b want 01", {act_in_rdy, err_in_rdy});
        end
    endtask

    task automatic test_bwd_gating();
        logic [31:0] exp_e [4];
        exp_e = '{32'h1111_1101, 32'h0, 32'h3333_3301, 32'h4444_4401};
        vec  = '{32'h1111_1101, 32'h2222_2201, 32'h3333_3301, 32'h4444_4401};
        fvec = '{1'b1, 1'b0, 1'b0, 1'b0};
        clear_got();
        push_bwd(0, 1'b0);
        drain();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_e.size() != 4 || got_e[k] !== exp_e[k] || got_ef[k] !== (k == 0)) begin
                errors++;
                $display("FAIL gate_elem%0d: got %h fst %b want %h fst %b", k, got_e[k],
                         got_ef[k], exp_e[k], k == 0);
            end
        end
        checks++;
        if (act_in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL gate_to_fwd: got act_in_rdy %b want 1", act_in_rdy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] src[$];
        rand_frame(8);
        src = vec;
        clear_got();
        push_fwd(7'd8, 1'b0, 1);
        drain();
        checks++;
        if (got_a.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d want 8", got_a.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (got_a[k] !== (src[k][31] ? 32'h0 : src[k])) begin
                    errors++;
                    $display("FAIL bp_order%0d: got %h want %h", k, got_a[k],
                             src[k][31] ? 32'h0 : src[k]);
                end
            end
        end
        rand_frame(8);
        push_bwd(1, 1'b0);
        drain();
    endtask

    task automatic test_blocking();
        bit aa, ea;
        rand_frame(4);
        push_fwd(7'd4, 1'b0, 0);
        drain();
        rand_frame(4);
        push_bwd(0, 1'b1);
        drain();
        checks++;
        if (act_in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL block_release: got act_in_rdy %b want 1", act_in_rdy);
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 7'd4, 1'b0, 1'b1, 1'b1, 32'h5555_5501, 1'b1, 1'b1,
                        aa, ea);
            checks++;
            if (err_in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL block_err_in_fwd: got err_in_rdy %b want 0", err_in_rdy);
            end
        end
    endtask

    task automatic test_resync();
        rand_frame(5);
        fvec[2] = 1'b1;
        push_fwd(7'd4, 1'b0, 0);
        drain();
        checks++;
        if (act_in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL resync_still_fwd: got act_in_rdy %b want 1", act_in_rdy);
        end
        vec  = '{32'h0100_0002};
        fvec = '{1'b0};
        push_fwd(7'd4, 1'b0, 0);
        drain();
        checks++;
        if ({act_in_rdy, err_in_rdy} !== 2'b01) begin
            errors++;
            $display("FAIL resync_to_bwd: got rdy %b want 01", {act_in_rdy, err_in_rdy});
        end
        rand_frame(4);
        push_bwd(0, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid();
        bit aa, ea;
        drive_cycle(1'b1, 1'b1, 32'h0200_0003, 7'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                    aa, ea);
        drive_cycle(1'b0, 1'b0, 32'h0, 7'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, aa, ea);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({act_out_vld, err_out_vld, act_in_rdy, err_in_rdy} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset: got vld/rdy %b want 0000",
                     {act_out_vld, err_out_vld, act_in_rdy, err_in_rdy});
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        // After reset the latched length is 1, so a single element without fst ends the frame
        vec  = '{32'h8000_0101};
        fvec = '{1'b0};
        clear_got();
        push_fwd(7'd4, 1'b0, 0);
        drain();
        checks++;
        if (err_in_rdy !== 1'b1 || got_a.size() != 1 || got_af[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_len1: got err_in_rdy %b outs %0d want 1 outs 1", err_in_rdy,
                     got_a.size());
        end
        vec  = '{32'h7777_7701};
        push_bwd(0, 1'b0);
        drain();
    endtask

    task automatic test_length_edges();
        rand_frame(1);
        push_fwd(7'd0, 1'b0, 0);
        drain();
        checks++;
        if ({act_in_rdy, err_in_rdy} !== 2'b01) begin
            errors++;
            $display("FAIL len0_to_bwd: got rdy %b want 01", {act_in_rdy, err_in_rdy});
        end
        push_bwd(0, 1'b0);
        drain();
        rand_frame(64);
        clear_got();
        push_fwd(7'd100, 1'b0, 0);
        drain();
        checks++;
        if (got_a.size() != 64 || err_in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL len100_clip: got %0d outs err_in_rdy %b want 64 outs 1",
                     got_a.size(), err_in_rdy);
        end
        rand_frame(64);
        push_bwd(0, 1'b0);
        drain();
        vec  = '{32'h8000_0005, 32'hFFFF_FF01};
        fvec = '{1'b1, 1'b0};
        clear_got();
        push_fwd(7'd2, 1'b1, 0);
        drain();
        vec = '{32'hAAAA_AA01, 32'hBBBB_BB01};
        push_bwd(0, 1'b0);
        drain();
        checks++;
        if (got_a.size() != 2 || got_a[0] !== 32'h8000_0005 || got_e.size() != 2 ||
            got_e[0] !== 32'hAAAA_AA01 || got_e[1] !== 32'hBBBB_BB01) begin
            errors++;
            $display("FAIL bypass: got act %h err %h %h want 80000005 err aaaaaa01 bbbbbb01",
                     got_a[0], got_e[0], got_e[1]);
        end
    endtask

    task automatic test_random();
        int n;
        bit byp;
        for (int fr = 0; fr < 6; fr++) begin
            n = $urandom_range(1, 70);
            byp = ($urandom_range(0, 3) == 0);
            rand_frame(n > MAX_LEN ? MAX_LEN : n);
            push_fwd(7'(n), byp, 2);
            drain();
            rand_frame(n > MAX_LEN ? MAX_LEN : n);
            fvec[0] = 1'($urandom_range(0, 1));
            push_bwd(2, 1'b0);
            drain();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fwd_relu();
        test_bwd_gating();
        test_backpressure();
        test_blocking();
        test_resync();
        test_reset_mid();
        test_length_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
